// File: rtl/mephi_bus_arb.sv
// -----------------------------------------------------------------------------
// mephi_bus_arb
//
// Shared-bus arbiter/router for the MEPHI CPU system. NUM_M masters compete
// for one fabric; a round-robin arbiter picks one request at a time. The
// winner's address is decoded into either the IO window or memory, and the
// transaction is forwarded to that slave. When the slave acks, the read data
// is returned to the granted master with a one-cycle ack pulse. Only one
// transaction is in flight at any time, so the best-case rate is one
// transaction every three cycles.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   Defined     : a watchdog ends a REQ phase after TIMEOUT cycles without a
//                 slave ack. The master then gets ack+err and all-ones data.
//   Not defined : REQ waits for the slave indefinitely; m_err_o is tied 0.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst     in   synchronous reset, active-low
//   m_stb_i     in   [NUM_M]      per-master request strobe
//   m_we_i      in   [NUM_M]      per-master write enable
//   m_addr_i    in   [NUM_M*AW]   packed addresses, master k at [k*AW +: AW]
//   m_data_i    in   [NUM_M*DW]   packed write data, master k at [k*DW +: DW]
//   m_data_o    out  [DW]         shared read data, held between acks
//   m_ack_o     out  [NUM_M]      one-hot, one-cycle completion pulse
//   m_err_o     out  [NUM_M]      one-hot error pulse, coincident with ack
//   mem_*_o     out               memory slave stb / we / addr / write data
//   mem_*_i     in                memory slave read data / ack
//   io_*_o      out               IO slave stb / we / addr / write data
//   io_*_i      in                IO slave read data / ack
// -----------------------------------------------------------------------------
module mephi_bus_arb #(
    parameter int              NUM_M   = 2,
    parameter int              AW      = 16,
    parameter int              DW      = 16,
    parameter logic [AW-1:0]   IO_BASE = AW'(16'hFF00),
    parameter logic [AW-1:0]   IO_MASK = AW'(16'hFF00),
    parameter int              TIMEOUT = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_M-1:0]    m_stb_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_data_i,
    output logic [DW-1:0]       m_data_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic                mem_stb_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_data_o,
    input  logic [DW-1:0]       mem_data_i,
    input  logic                mem_ack_i,
    output logic                io_stb_o,
    output logic                io_we_o,
    output logic [AW-1:0]       io_addr_o,
    output logic [DW-1:0]       io_data_o,
    input  logic [DW-1:0]       io_data_i,
    input  logic                io_ack_i
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    if (NUM_M < 2 || NUM_M > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mephi_bus_arb: NUM_M must be 2..8 and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [IW-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [IW-1:0]      grant_q,   grant_d;
    logic               io_sel_q,  io_sel_d;
    logic [AW-1:0]      addr_q,    addr_d;
    logic [DW-1:0]      wdata_q,   wdata_d;
    logic               mem_stb_q, mem_stb_d;
    logic               mem_we_q,  mem_we_d;
    logic               io_stb_q,  io_stb_d;
    logic               io_we_q,   io_we_d;
    logic [DW-1:0]      rdata_q,   rdata_d;
    logic [NUM_M-1:0]   ack_q,     ack_d;

    // Arbitration result for the current cycle (only consumed in IDLE).
    logic               arb_found;
    logic [IW-1:0]      arb_idx;
    logic [AW-1:0]      win_addr;
    logic [DW-1:0]      win_data;
    logic               win_we;
    logic               win_io;

    // Ack from whichever slave the latched request targets; the other
    // slave's ack never reaches the FSM.
    logic               sel_ack;
    logic [DW-1:0]      sel_rdata;
    logic               expire;

`ifdef BUS_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [NUM_M-1:0]   err_q,     err_d;

    // The counter holds the number of REQ cycles already spent, so the
    // watchdog fires in the cycle that would bring it to TIMEOUT.
    assign expire  = (tmo_cnt_q == TW'(TIMEOUT - 1));
    assign m_err_o = err_q;
`else
    assign expire  = 1'b0;
    assign m_err_o = '0;
`endif

    // Round-robin scan: start just above the last served master so it has
    // the lowest priority in the next round.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= NUM_M; i++) begin : scan
            int cand;
            cand = (int'(rr_ptr_q) + i) % NUM_M;
            if (!arb_found && m_stb_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(cand);
            end
        end
    end

    assign win_addr  = m_addr_i[arb_idx*AW +: AW];
    assign win_data  = m_data_i[arb_idx*DW +: DW];
    assign win_we    = m_we_i[arb_idx];
    assign win_io    = ((win_addr & IO_MASK) == IO_BASE);

    assign sel_ack   = io_sel_q ? io_ack_i  : mem_ack_i;
    assign sel_rdata = io_sel_q ? io_data_i : mem_data_i;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        io_sel_d  = io_sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_stb_d = mem_stb_q;
        mem_we_d  = mem_we_q;
        io_stb_d  = io_stb_q;
        io_we_d   = io_we_q;
        rdata_d   = rdata_q;
        ack_d     = '0;
`ifdef BUS_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = '0;
`endif

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d   = arb_idx;
                    io_sel_d  = win_io;
                    addr_d    = win_addr;
                    wdata_d   = win_data;
                    mem_stb_d = !win_io;
                    mem_we_d  = !win_io && win_we;
                    io_stb_d  = win_io;
                    io_we_d   = win_io && win_we;
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                    state_d   = REQ;
                end
            end

            REQ: begin
                // A real ack beats a watchdog expiry in the same cycle.
                if (sel_ack || expire) begin
                    mem_stb_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    io_stb_d       = 1'b0;
                    io_we_d        = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    rdata_d        = sel_ack ? sel_rdata : {DW{1'b1}};
`ifdef BUS_TIMEOUT_EN
                    err_d[grant_q] = !sel_ack;
`endif
                    state_d        = RESP;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end

            RESP: begin
                rr_ptr_d = grant_q;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= IW'(NUM_M - 1);
            grant_q   <= '0;
            io_sel_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_stb_q <= 1'b0;
            mem_we_q  <= 1'b0;
            io_stb_q  <= 1'b0;
            io_we_q   <= 1'b0;
            rdata_q   <= '0;
            ack_q     <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            io_sel_q  <= io_sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_stb_q <= mem_stb_d;
            mem_we_q  <= mem_we_d;
            io_stb_q  <= io_stb_d;
            io_we_q   <= io_we_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Both slaves see the same latched address/data; only the strobe and
    // write enable distinguish the target.
    assign m_data_o   = rdata_q;
    assign m_ack_o    = ack_q;
    assign mem_stb_o  = mem_stb_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = addr_q;
    assign mem_data_o = wdata_q;
    assign io_stb_o   = io_stb_q;
    assign io_we_o    = io_we_q;
    assign io_addr_o  = addr_q;
    assign io_data_o  = wdata_q;

endmodule

// File: tb/tb_mephi_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_mephi_bus_arb
//
// Bench for mephi_bus_arb with two masters. Behavioural memory and IO slaves
// answer with programmable wait states and can inject stray acks while idle.
// Directed sequences cover reset, decode, latency, round-robin alternation,
// wait states and reset during a request; randomized rounds compare the
// order of grants and returned data with a round-robin reference model.
// -----------------------------------------------------------------------------
module tb_mephi_bus_arb;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              sys_rst;
    logic [N-1:0]      m_stb_i;
    logic [N-1:0]      m_we_i;
    logic [N*AW-1:0]   m_addr_i;
    logic [N*DW-1:0]   m_data_i;
    logic [DW-1:0]     m_data_o;
    logic [N-1:0]      m_ack_o;
    logic [N-1:0]      m_err_o;
    logic              mem_stb_o, mem_we_o, io_stb_o, io_we_o;
    logic [AW-1:0]     mem_addr_o, io_addr_o;
    logic [DW-1:0]     mem_data_o, io_data_o;
    logic [DW-1:0]     mem_data_i = '0;
    logic [DW-1:0]     io_data_i  = '0;
    logic              mem_ack_i  = 1'b0;
    logic              io_ack_i   = 1'b0;

    mephi_bus_arb #(
        .NUM_M   (N),
        .AW      (AW),
        .DW      (DW),
        .IO_BASE (16'hFF00),
        .IO_MASK (16'hFF00),
        .TIMEOUT (8)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .m_stb_i    (m_stb_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_data_i   (m_data_i),
        .m_data_o   (m_data_o),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .mem_stb_o  (mem_stb_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .io_stb_o   (io_stb_o),
        .io_we_o    (io_we_o),
        .io_addr_o  (io_addr_o),
        .io_data_o  (io_data_o),
        .io_data_i  (io_data_i),
        .io_ack_i   (io_ack_i)
    );

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a * 16'd5) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] io_fn(input logic [15:0] a);
        return ~a;
    endfunction

    // ---------------- slave models ----------------
    int          mem_wait = 0;
    int          io_wait  = 0;
    int          mem_cnt  = 0;
    int          io_cnt   = 0;
    logic        mem_fixed_en = 1'b0;
    logic [15:0] mem_fixed    = '0;
    logic        stray_en     = 1'b0;
    logic        io_force     = 1'b0;
    logic        cap_io       = 1'b0;
    logic [15:0] cap_addr     = '0;
    logic        cap_we       = 1'b0;
    logic [15:0] cap_wdata    = '0;

    always @(posedge clk) begin
        #2;
        if (mem_stb_o) begin
            if (mem_cnt == mem_wait) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem_fixed_en ? mem_fixed : mem_fn(mem_addr_o);
                cap_io     = 1'b0;
                cap_addr   = mem_addr_o;
                cap_we     = mem_we_o;
                cap_wdata  = mem_data_o;
            end else begin
                mem_ack_i = 1'b0;
                mem_cnt++;
            end
        end else begin
            mem_cnt    = 0;
            mem_ack_i  = stray_en && ($urandom_range(0, 3) == 0);
            mem_data_i = 16'($urandom);
        end

        if (io_stb_o) begin
            if (io_cnt == io_wait) begin
                io_ack_i  = 1'b1;
                io_data_i = io_fn(io_addr_o);
                cap_io    = 1'b1;
                cap_addr  = io_addr_o;
                cap_we    = io_we_o;
                cap_wdata = io_data_o;
            end else begin
                io_ack_i = 1'b0;
                io_cnt++;
            end
        end else begin
            io_cnt    = 0;
            io_ack_i  = io_force || (stray_en && ($urandom_range(0, 3) == 0));
            io_data_i = 16'($urandom);
        end
    end

    task automatic set_req(input int k, input logic [15:0] a, input logic we, input logic [15:0] d);
        m_stb_i[k]            = 1'b1;
        m_we_i[k]             = we;
        m_addr_i[k*AW +: AW]  = a;
        m_data_i[k*DW +: DW]  = d;
    endtask

    // ---------------- reference model state ----------------
    int          rr_model;
    int          exp_q[$];
    logic [15:0] r_addr [N];
    logic        r_we   [N];
    logic [15:0] r_data [N];

    initial begin
        sys_rst  = 1'b0;
        m_stb_i  = '0;
        m_we_i   = '0;
        m_addr_i = '0;
        m_data_i = '0;

        // Reset state
        tick();
        tick();
        check_val("rst_ack",     m_ack_o,    0);
        check_val("rst_err",     m_err_o,    0);
        check_val("rst_mem_stb", mem_stb_o,  0);
        check_val("rst_io_stb",  io_stb_o,   0);
        check_val("rst_data",    m_data_o,   0);
        check_val("rst_addr",    mem_addr_o, 0);
        check_val("rst_we",      {mem_we_o, io_we_o}, 0);
        sys_rst = 1'b1;

        // Single read, master 0, zero-wait memory
        mem_fixed_en = 1'b1;
        mem_fixed    = 16'h1234;
        set_req(0, 16'h0010, 1'b0, 16'h0000);
        tick();
        check_val("rd_mem_stb_c1", mem_stb_o,  1);
        check_val("rd_io_stb_c1",  io_stb_o,   0);
        check_val("rd_addr_c1",    mem_addr_o, 16'h0010);
        check_val("rd_we_c1",      mem_we_o,   0);
        check_val("rd_ack_c1",     m_ack_o,    0);
        tick();
        check_val("rd_ack_c2",     m_ack_o,    2'b01);
        check_val("rd_data_c2",    m_data_o,   16'h1234);
        check_val("rd_mem_stb_c2", mem_stb_o,  0);
        check_val("rd_io_stb_c2",  io_stb_o,   0);
        m_stb_i[0]   = 1'b0;
        mem_fixed_en = 1'b0;
        tick();
        check_val("rd_ack_c3",  m_ack_o,  0);
        check_val("rd_hold_c3", m_data_o, 16'h1234);

        // IO decode write, master 1, one wait state
        io_wait = 1;
        set_req(1, 16'hFF04, 1'b1, 16'hABCD);
        tick();
        check_val("io_stb_c1",     io_stb_o,  1);
        check_val("io_we_c1",      io_we_o,   1);
        check_val("io_wdata_c1",   io_data_o, 16'hABCD);
        check_val("io_addr_c1",    io_addr_o, 16'hFF04);
        check_val("io_mem_stb_c1", mem_stb_o, 0);
        tick();
        check_val("io_stb_c2", io_stb_o, 1);
        check_val("io_ack_c2", m_ack_o,  0);
        tick();
        check_val("io_ack_c3",  m_ack_o,  2'b10);
        check_val("io_data_c3", m_data_o, io_fn(16'hFF04));
        check_val("io_stb_c3",  io_stb_o, 0);
        m_stb_i = '0;
        m_we_i  = '0;
        io_wait = 0;
        tick();
        check_val("io_ack_c4", m_ack_o, 0);

        // Round-robin with both masters requesting continuously
        set_req(0, 16'h0100, 1'b0, 16'h0000);
        set_req(1, 16'h0200, 1'b0, 16'h0000);
        for (int t = 1; t <= 11; t++) begin
            logic [1:0] exp_ack;
            tick();
            exp_ack = 2'b00;
            if (t % 3 == 2) exp_ack = ((t / 3) % 2 == 0) ? 2'b01 : 2'b10;
            check_val($sformatf("rr_ack_t%0d", t), m_ack_o, exp_ack);
            check_val($sformatf("rr_stb_t%0d", t), mem_stb_o, (t % 3 == 1) ? 1 : 0);
            if (exp_ack != 0)
                check_val($sformatf("rr_data_t%0d", t), m_data_o,
                          mem_fn((exp_ack == 2'b01) ? 16'h0100 : 16'h0200));
        end
        m_stb_i = '0;
        tick();

        // Wait states with a stray IO ack during the wait
        mem_wait = 4;
        set_req(0, 16'h0300, 1'b0, 16'h0000);
        for (int t = 1; t <= 7; t++) begin
            tick();
            io_force = (t == 2);
            check_val($sformatf("ws_stb_t%0d", t), mem_stb_o, (t >= 1 && t <= 5) ? 1 : 0);
            check_val($sformatf("ws_ack_t%0d", t), m_ack_o, (t == 6) ? 2'b01 : 2'b00);
            check_val($sformatf("ws_io_t%0d", t),  io_stb_o, 0);
            if (t == 6) begin
                check_val("ws_data", m_data_o, mem_fn(16'h0300));
                m_stb_i = '0;
            end
        end
        io_force = 1'b0;

        // Reset during REQ; master 1 would win without the reset
        mem_wait = 1000;
        set_req(0, 16'h0400, 1'b0, 16'h0000);
        tick();
        check_val("rq_stb_t1", mem_stb_o, 1);
        set_req(1, 16'h0500, 1'b0, 16'h0000);
        tick();
        check_val("rq_addr_t2", mem_addr_o, 16'h0400);
        sys_rst = 1'b0;
        tick();
        check_val("rq_stb_t3",  mem_stb_o,  0);
        check_val("rq_ack_t3",  m_ack_o,    0);
        check_val("rq_data_t3", m_data_o,   0);
        check_val("rq_addr_t3", mem_addr_o, 0);
        sys_rst  = 1'b1;
        mem_wait = 0;
        tick();
        check_val("rq_stb_t4",  mem_stb_o,  1);
        check_val("rq_win_t4",  mem_addr_o, 16'h0400);
        check_val("rq_ack_t4",  m_ack_o,    0);
        tick();
        check_val("rq_ack_t5",  m_ack_o,    2'b01);
        m_stb_i[0] = 1'b0;
        for (int t = 6; t <= 8; t++) begin
            tick();
            check_val($sformatf("rq_ack_t%0d", t), m_ack_o, (t == 8) ? 2'b10 : 2'b00);
        end
        m_stb_i  = '0;
        rr_model = 1;

`ifdef BUS_TIMEOUT_EN
        // Watchdog: memory never acks
        mem_wait = 1000;
        set_req(0, 16'h0600, 1'b0, 16'h0000);
        for (int t = 1; t <= 10; t++) begin
            tick();
            check_val($sformatf("to_stb_t%0d", t), mem_stb_o, (t <= 8) ? 1 : 0);
            check_val($sformatf("to_ack_t%0d", t), m_ack_o, (t == 9) ? 2'b01 : 2'b00);
            check_val($sformatf("to_err_t%0d", t), m_err_o, (t == 9) ? 2'b01 : 2'b00);
            if (t == 9) begin
                check_val("to_data", m_data_o, 16'hFFFF);
                m_stb_i = '0;
            end
        end
        mem_wait = 0;
        rr_model = 0;
`endif

        // Randomized rounds against the round-robin reference model
        stray_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] req;
            logic [N-1:0] pend;
            logic         exp_io;
            int           k;
            req      = N'($urandom_range(1, (1 << N) - 1));
            mem_wait = $urandom_range(0, 3);
            io_wait  = $urandom_range(0, 3);
            for (int m = 0; m < N; m++) begin
                if ($urandom_range(0, 2) == 0)
                    r_addr[m] = {8'hFF, 8'($urandom)};
                else
                    r_addr[m] = {8'($urandom_range(0, 254)), 8'($urandom)};
                r_we[m]   = 1'($urandom);
                r_data[m] = 16'($urandom);
                if (req[m]) set_req(m, r_addr[m], r_we[m], r_data[m]);
            end

            // Expected service order: every pending master is served once,
            // each time scanning upward from the last served master.
            exp_q.delete();
            pend = req;
            while (pend != 0) begin
                for (int j = 1; j <= N; j++) begin
                    int c;
                    c = (rr_model + j) % N;
                    if (pend[c]) begin
                        exp_q.push_back(c);
                        pend[c]  = 1'b0;
                        rr_model = c;
                        break;
                    end
                end
            end

            for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
                tick();
                check_val("rnd_one_stb", {31'd0, mem_stb_o & io_stb_o}, 0);
                if (m_ack_o != 0) begin
                    if (exp_q.size() == 0) begin
                        check_val("rnd_extra_ack", m_ack_o, 0);
                    end else begin
                        k      = exp_q.pop_front();
                        exp_io = ((r_addr[k] & 16'hFF00) == 16'hFF00);
                        check_val("rnd_grant", m_ack_o, 1 << k);
                        check_val("rnd_err",   m_err_o, 0);
                        check_val("rnd_data",  m_data_o, exp_io ? io_fn(r_addr[k]) : mem_fn(r_addr[k]));
                        check_val("rnd_route", cap_io,   exp_io);
                        check_val("rnd_addr",  cap_addr, r_addr[k]);
                        check_val("rnd_we",    cap_we,   r_we[k]);
                        if (r_we[k]) check_val("rnd_wdata", cap_wdata, r_data[k]);
                        m_stb_i[k] = 1'b0;
                    end
                end
            end
            check_val("rnd_all_served", exp_q.size(), 0);
            m_stb_i = '0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
